// File: rtl/mig_bus_rr_arbiter_pkg.sv
// MIG native-bus layout shared by every MIG-bus block: widths, field offsets, slot helpers.
package mig_bus_rr_arbiter_pkg;

    localparam int MIG_ADDR_W     = 32;
    localparam int MIG_DATA_W     = 256;
    localparam int MIG_STRB_W     = MIG_DATA_W / 8;
    localparam int REQ_MIG_BUS_W  = 1 + MIG_ADDR_W + MIG_DATA_W + MIG_STRB_W;
    localparam int RESP_MIG_BUS_W = MIG_DATA_W + 1;

    // Field offsets within one slot, LSB-relative, for the default widths.
    localparam int REQ_STRB_OFS   = 0;
    localparam int REQ_WDATA_OFS  = MIG_STRB_W;
    localparam int REQ_ADDR_OFS   = MIG_STRB_W + MIG_DATA_W;
    localparam int REQ_VALID_OFS  = REQ_ADDR_OFS + MIG_ADDR_W;
    localparam int RESP_READY_OFS = 0;
    localparam int RESP_RDATA_OFS = 1;

    typedef struct packed {
        logic                  valid;
        logic [MIG_ADDR_W-1:0] addr;
        logic [MIG_DATA_W-1:0] wdata;
        logic [MIG_STRB_W-1:0] wstrb;
    } mig_req_t;

    typedef struct packed {
        logic [MIG_DATA_W-1:0] rdata;
        logic                  ready;
    } mig_resp_t;

    // Width-generic helpers for blocks that override the default widths.
    function automatic int req_bus_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    function automatic int resp_bus_w(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int req_valid_bit(input int addr_w, input int data_w);
        return req_bus_w(addr_w, data_w) - 1;
    endfunction

    function automatic int req_slot_lsb(input int slot, input int addr_w, input int data_w);
        return slot * req_bus_w(addr_w, data_w);
    endfunction

    function automatic int resp_slot_lsb(input int slot, input int data_w);
        return slot * resp_bus_w(data_w);
    endfunction

endpackage

// File: rtl/mig_bus_rr_arbiter_rr_prio_enc.sv
// Round-robin priority encoder: first set request bit scanning ptr, ptr+1, ... mod N.
// Latency: combinational.
// Backpressure: none; pure function of req and ptr.
module rr_prio_enc #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any_vld
);

    localparam int             IDX_W = $clog2(N);
    localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(N);

    logic [IDX_W:0] pos;

    // Scan from the farthest offset down so the nearest hit to ptr wins.
    // ptr is always < N, so a single subtract is enough to wrap.
    always_comb begin
        idx     = '0;
        any_vld = 1'b0;
        pos     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            pos = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (pos >= N_EXT) begin
                pos = pos - N_EXT;
            end
            if (req[pos[IDX_W-1:0]]) begin
                idx     = pos[IDX_W-1:0];
                any_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mig_bus_rr_arbiter.sv
// Round-robin arbiter of N cache back-ends onto one L2 MIG-bus front-end.
// Latency: 1 cycle from request in IDLE to s_req valid; one transaction in flight.
// Backpressure: grant held until L2 ready; ready routed only to the granted master.
module mig_bus_rr_arbiter
    import mig_bus_rr_arbiter_pkg::*;
#(
    parameter int ADDR_W    = MIG_ADDR_W,
    parameter int DATA_W    = MIG_DATA_W,
    parameter int N_MASTERS = 2
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [N_MASTERS*(1+ADDR_W+DATA_W+DATA_W/8)-1:0]      m_req,
    output logic [N_MASTERS*(DATA_W+1)-1:0]                      m_resp,
    output logic [(1+ADDR_W+DATA_W+DATA_W/8)-1:0]                s_req,
    input  logic [DATA_W:0]                                      s_resp,
    output logic                                                 busy,
    output logic [$clog2(N_MASTERS)-1:0]                         grant_idx
);

    localparam int REQ_W   = req_bus_w(ADDR_W, DATA_W);
    localparam int RESP_W  = resp_bus_w(DATA_W);
    localparam int VLD_BIT = req_valid_bit(ADDR_W, DATA_W);
    localparam int IDX_W   = $clog2(N_MASTERS);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [IDX_W-1:0]   sel, sel_nxt;
    logic [REQ_W-1:0]   m_slot [N_MASTERS];
    logic [N_MASTERS-1:0] m_vld;
    logic [IDX_W-1:0]   enc_idx;
    logic               enc_any;
    logic               s_rdy;

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_slot
        assign m_slot[i] = m_req[req_slot_lsb(i, ADDR_W, DATA_W) +: REQ_W];
        assign m_vld[i]  = m_slot[i][VLD_BIT];
    end

    assign s_rdy = s_resp[RESP_READY_OFS];

    rr_prio_enc #(
        .N (N_MASTERS)
    ) u_enc (
        .req     (m_vld),
        .ptr     (ptr),
        .idx     (enc_idx),
        .any_vld (enc_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            sel   <= sel_nxt;
        end
    end

    // GRANT always falls back to IDLE, so back-to-back grants are impossible.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        case (state)
            IDLE: begin
                if (enc_any) begin
                    state_nxt = GRANT;
                    sel_nxt   = enc_idx;
                end
            end
            GRANT: begin
                if (s_rdy) begin
                    state_nxt = IDLE;
                    ptr_nxt   = (sel == IDX_W'(N_MASTERS - 1)) ? '0 : sel + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The selected slot is forwarded verbatim, including a dropped valid.
    always_comb begin
        s_req  = '0;
        m_resp = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            m_resp[i*RESP_W + RESP_RDATA_OFS +: DATA_W] = s_resp[RESP_RDATA_OFS +: DATA_W];
            if (state == GRANT && sel == IDX_W'(i)) begin
                s_req                               = m_slot[i];
                m_resp[i*RESP_W + RESP_READY_OFS]   = s_rdy;
            end
        end
    end

    assign busy      = (state == GRANT);
    assign grant_idx = sel;

endmodule

// File: tb/tb_mig_bus_rr_arbiter.sv
// Directed bench: a 2-master and a 3-master arbiter share stimulus; cur picks the one under check.
module tb_mig_bus_rr_arbiter;
    import mig_bus_rr_arbiter_pkg::*;

    localparam int REQ_W  = REQ_MIG_BUS_W;
    localparam int RESP_W = RESP_MIG_BUS_W;
    localparam int NMAX   = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [REQ_W-1:0]      slot [NMAX];
    logic [NMAX*REQ_W-1:0] m_req;
    logic [RESP_W-1:0]     s_resp;
    assign m_req = {slot[2], slot[1], slot[0]};

    logic [2*RESP_W-1:0] m_resp0;
    logic [3*RESP_W-1:0] m_resp1;
    logic [REQ_W-1:0]    s_req0, s_req1;
    logic                busy0, busy1;
    logic                gidx0;
    logic [1:0]          gidx1;

    mig_bus_rr_arbiter #(.ADDR_W(MIG_ADDR_W), .DATA_W(MIG_DATA_W), .N_MASTERS(2)) dut0 (
        .clk(clk), .rst(rst), .m_req(m_req[2*REQ_W-1:0]), .m_resp(m_resp0),
        .s_req(s_req0), .s_resp(s_resp), .busy(busy0), .grant_idx(gidx0)
    );

    mig_bus_rr_arbiter #(.ADDR_W(MIG_ADDR_W), .DATA_W(MIG_DATA_W), .N_MASTERS(3)) dut1 (
        .clk(clk), .rst(rst), .m_req(m_req), .m_resp(m_resp1),
        .s_req(s_req1), .s_resp(s_resp), .busy(busy1), .grant_idx(gidx1)
    );

    int                   cur = 0;
    logic [NMAX*RESP_W-1:0] resp_v;
    logic [REQ_W-1:0]     sreq_v;
    logic                 busy_v;
    logic [1:0]           gidx_v;
    logic [NMAX-1:0]      rdy_v;

    assign resp_v = (cur == 1) ? m_resp1 : {{RESP_W{1'b0}}, m_resp0};
    assign sreq_v = (cur == 1) ? s_req1 : s_req0;
    assign busy_v = (cur == 1) ? busy1 : busy0;
    assign gidx_v = (cur == 1) ? gidx1 : {1'b0, gidx0};

    always_comb begin
        rdy_v = '0;
        for (int i = 0; i < NMAX; i++) rdy_v[i] = resp_v[i*RESP_W];
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, want);
    endtask

    // Exactly one master sees ready per L2 ready while granted, none otherwise.
    always @(negedge clk) begin
        chk("one_rdy_per_l2_rdy", 512'($countones(rdy_v)), 512'((busy_v && s_resp[0]) ? 1 : 0));
    end

    function automatic logic [REQ_W-1:0] req_word(input int i);
        mig_req_t r;
        r.valid = 1'b1;
        r.addr  = 32'h100 + 32'(i) * 32'h40;
        r.wdata = {32{8'(8'h10 + i)}};
        r.wstrb = 32'(1) << i;
        return r;
    endfunction

    task automatic set_mask(input logic [2:0] mask);
        for (int i = 0; i < NMAX; i++) slot[i] = mask[i] ? req_word(i) : '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] mask);
        rst    = 1'b1;
        s_resp = '0;
        set_mask(mask);
        #1;
        chk("rst_busy", 512'(busy_v), 512'(0));
        chk("rst_gidx", 512'(gidx_v), 512'(0));
        chk("rst_s_vld", 512'(sreq_v[REQ_W-1]), 512'(0));
        chk("rst_rdy", 512'(rdy_v), 512'(0));
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One full transaction starting in IDLE; L2 answers on GRANT cycle lat.
    task automatic run_txn(input logic [2:0] mask, input int lat, input logic [7:0] rb, input int gi);
        logic [REQ_W-1:0] want;
        logic [2:0]       onehot;
        set_mask(mask);
        want   = slot[gi];
        onehot = 3'b001 << gi;
        #1;
        chk("idle_busy", 512'(busy_v), 512'(0));
        chk("idle_s_vld", 512'(sreq_v[REQ_W-1]), 512'(0));
        tick();
        chk("grant_idx", 512'(gidx_v), 512'(gi));
        chk("grant_busy", 512'(busy_v), 512'(1));
        for (int c = 1; c < lat; c++) begin
            chk("s_req_held", 512'(sreq_v), 512'(want));
            chk("rdy_wait", 512'(rdy_v), 512'(0));
            tick();
        end
        chk("s_req", 512'(sreq_v), 512'(want));
        s_resp = {{32{rb}}, 1'b1};
        #1;
        chk("rdy_route", 512'(rdy_v), 512'(onehot));
        for (int i = 0; i < ((cur == 1) ? 3 : 2); i++)
            chk("rdata_fan", 512'(resp_v[i*RESP_W+1 +: MIG_DATA_W]), 512'({32{rb}}));
        tick();
        s_resp   = '0;
        slot[gi] = '0;
        #1;
        chk("release_busy", 512'(busy_v), 512'(0));
        chk("release_rdy", 512'(rdy_v), 512'(0));
    endtask

    typedef struct {
        logic [2:0] vld;
        int         lat;
        logic [7:0] rbyte;
        int         gi;
    } vec_t;

    vec_t tbl [7];
    mig_req_t wr;

    initial begin
        rst    = 1'b1;
        s_resp = '0;
        set_mask(3'b000);

        // Sequential from reset (ptr 0); expected grant tracks ptr by hand.
        tbl[0] = '{3'b001, 3, 8'hA5, 0};  // ptr -> 1
        tbl[1] = '{3'b001, 1, 8'h11, 0};  // scan 1,0 -> 0; ptr -> 1
        tbl[2] = '{3'b011, 2, 8'h22, 1};  // ptr -> 0
        tbl[3] = '{3'b011, 1, 8'h33, 0};  // ptr -> 1
        tbl[4] = '{3'b010, 4, 8'h44, 1};  // ptr -> 0
        tbl[5] = '{3'b010, 1, 8'h55, 1};  // ptr -> 0
        tbl[6] = '{3'b011, 2, 8'h66, 0};  // ptr -> 1

        cur = 0;
        do_reset(3'b000);
        for (int t = 0; t < 7; t++) run_txn(tbl[t].vld, tbl[t].lat, tbl[t].rbyte, tbl[t].gi);

        // Both valid across reset release, held continuously: strict alternation.
        do_reset(3'b011);
        for (int t = 0; t < 6; t++) run_txn(3'b011, 1 + (t % 3), 8'(8'h80 + t), t % 2);

        // m1 write granted; m0 arrives mid-grant and must wait.
        do_reset(3'b000);
        wr.valid = 1'b1;
        wr.addr  = 32'h0000_0200;
        wr.wdata = {8{32'hDEAD_BEEF}};
        wr.wstrb = '1;
        slot[1]  = wr;
        tick();
        chk("wr_gidx", 512'(gidx_v), 512'(1));
        chk("wr_s_req", 512'(sreq_v), 512'(wr));
        slot[0] = req_word(0);
        #1;
        chk("wr_s_req_m0_pending", 512'(sreq_v), 512'(wr));
        chk("wr_no_rdy", 512'(rdy_v), 512'(0));
        tick();
        chk("wr_still_m1", 512'(gidx_v), 512'(1));
        chk("wr_s_req_held", 512'(sreq_v), 512'(wr));
        s_resp = {{32{8'hC3}}, 1'b1};
        #1;
        chk("wr_rdy_m1_only", 512'(rdy_v), 512'(3'b010));
        tick();
        s_resp  = '0;
        slot[1] = '0;
        #1;
        chk("wr_release", 512'(busy_v), 512'(0));
        run_txn(3'b001, 1, 8'h96, 0);

        // Reset during m1 grant with ptr at 1: abandoned, ptr back to 0.
        do_reset(3'b000);
        run_txn(3'b001, 1, 8'h12, 0);
        set_mask(3'b010);
        tick();
        chk("pre_rst_gidx", 512'(gidx_v), 512'(1));
        chk("pre_rst_busy", 512'(busy_v), 512'(1));
        s_resp = {{32{8'hEE}}, 1'b1};
        rst    = 1'b1;
        #1;
        chk("mid_rst_busy", 512'(busy_v), 512'(0));
        chk("mid_rst_s_vld", 512'(sreq_v[REQ_W-1]), 512'(0));
        chk("mid_rst_gidx", 512'(gidx_v), 512'(0));
        chk("mid_rst_rdy", 512'(rdy_v), 512'(0));
        tick();
        rst    = 1'b0;
        s_resp = '0;
        run_txn(3'b011, 1, 8'h34, 0);
        run_txn(3'b010, 2, 8'h5A, 1);

        // Three masters, ptr moved to 2, all valid: order 2,0,1.
        cur = 1;
        do_reset(3'b000);
        run_txn(3'b010, 1, 8'h77, 1);
        run_txn(3'b111, 2, 8'hB2, 2);
        run_txn(3'b111, 1, 8'hB0, 0);
        run_txn(3'b111, 3, 8'hB1, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
